// File: rtl/ceyloniac_ram_arbiter.sv
// ceyloniac_ram_arbiter: shares one RAM port between the core and an external req/gnt/ack requester.
// Optional forced grant against starvation: define CEYLONIAC_ARB_STARVE_EN.
module ceyloniac_ram_arbiter #(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int MAX_BURST      = 4,
    parameter int STARVE_LIMIT   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      core_mem_read,
    input  logic                      core_mem_write,
    input  logic [RAM_ADDR_WIDTH-1:0] core_addr,
    input  logic [RAM_DATA_WIDTH-1:0] core_write_data,
    output logic [RAM_DATA_WIDTH-1:0] core_read_data,
    output logic                      core_stall,
    input  logic                      ext_req,
    input  logic                      ext_we,
    input  logic [RAM_ADDR_WIDTH-1:0] ext_addr,
    input  logic [RAM_DATA_WIDTH-1:0] ext_write_data,
    output logic                      ext_gnt,
    output logic                      ext_ack,
    output logic [RAM_DATA_WIDTH-1:0] ext_read_data,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_write_data,
    output logic                      ram_read_enable,
    output logic                      ram_write_enable,
    input  logic [RAM_DATA_WIDTH-1:0] ram_read_data,
    output logic [1:0]                owner
);
    typedef enum logic [1:0] {CORE = 2'b00, EXT_ISSUE = 2'b01, EXT_ACK = 2'b10} state_t;
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t              state_q, state_d;
    logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
    logic [RAM_DATA_WIDTH-1:0] rd_q, rd_d;
    logic                force_grant, go, in_issue, in_ack, in_core;

    assign in_core  = state_q == CORE;
    assign in_issue = state_q == EXT_ISSUE;
    assign in_ack   = state_q == EXT_ACK;

`ifdef CEYLONIAC_ARB_STARVE_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    assign force_grant = in_core && ext_req && wait_cnt_q == WW'(STARVE_LIMIT);
    // Counter only runs while waiting in CORE; any grant restarts it.
    assign wait_cnt_d  = (!in_core || go) ? '0 :
                         (ext_req && wait_cnt_q != WW'(STARVE_LIMIT)) ? wait_cnt_q + 1'b1 : wait_cnt_q;
    always_ff @(posedge clk)
        wait_cnt_q <= !reset ? '0 : wait_cnt_d;
`else
    logic unused_starve;
    assign unused_starve = STARVE_LIMIT > 0;
    assign force_grant   = 1'b0;
`endif

    assign go = in_core && ext_req && ((!core_mem_read && !core_mem_write) || force_grant);

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            CORE:      state_d = go ? EXT_ISSUE : CORE;
            EXT_ISSUE: state_d = EXT_ACK;
            EXT_ACK: begin
                if (ext_req && int'(burst_cnt_q) + 1 < MAX_BURST) begin
                    state_d     = EXT_ISSUE;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end else begin
                    state_d     = CORE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = CORE;
                burst_cnt_d = '0;
            end
        endcase
    end

    assign rd_d = in_ack ? ram_read_data : rd_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= CORE;
            burst_cnt_q <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rd_q        <= rd_d;
        end
    end

    assign owner            = state_q;
    assign ext_gnt          = in_issue || in_ack;
    assign ext_ack          = in_ack && reset;
    assign core_stall       = ext_gnt || force_grant;
    assign core_read_data   = ram_read_data;
    // Read data is live from the RAM during the ack, then held from the capture register.
    assign ext_read_data    = in_ack ? ram_read_data : rd_q;
    assign ram_addr         = in_issue ? ext_addr : core_addr;
    assign ram_write_data   = in_issue ? ext_write_data : core_write_data;
    assign ram_read_enable  = reset && !force_grant && (in_issue ? !ext_we : in_core && core_mem_read);
    assign ram_write_enable = reset && !force_grant && (in_issue ? ext_we : in_core && core_mem_write);
endmodule
